// File: rtl/regfile_wr_demux_pkg.sv
// Purpose  : shared widths, the x0 register index and the address type for the RV32I register file.
// Latency  : n/a (declarations only).
// Backpress: n/a.
package rv_pkg;

    localparam int XLEN     = 32;
    localparam int NREGS    = 32;
    localparam int AW       = $clog2(NREGS);
    localparam int REG_ZERO = 0;

    typedef logic [AW-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_wr_demux_wr_decoder.sv
// Purpose  : one-hot write-enable decoder for the register file; bit 0 (x0) is never enabled.
// Latency  : combinational, 0 cycles.
// Backpress: none; the write is always accepted when enabled.
// Ports    : a3 - write address, we3 - write enable, we_vec - one-hot enables, one per register.
module wr_decoder #(
    parameter int NREGS = rv_pkg::NREGS,
    parameter int AW    = rv_pkg::AW
) (
    input  logic [AW-1:0]    a3,
    input  logic             we3,
    output logic [NREGS-1:0] we_vec
);
    import rv_pkg::*;

    always_comb begin
        we_vec = '0;
        if (we3) begin
            we_vec[a3] = 1'b1;
        end
        // x0 is hardwired to zero, so its enable is forced off here rather
        // than relying on the storage side to ignore it.
        we_vec[REG_ZERO] = 1'b0;
    end

endmodule

// File: rtl/regfile_wr_demux.sv
// Purpose  : RV32I architectural register file; one write port steered by a one-hot decoder, two combinational read ports.
// Latency  : write commits on clk rising edge; reads are 0-cycle (optional same-cycle forwarding when BYPASS=1).
// Backpress: none; every enabled write to a non-zero address commits.
// Ports    : clk/rst_n (sync, active-low), a1/a2 read addresses -> rd1/rd2,
//            a3/we3/wd3 write address/enable/data, wr_cnt committed-write counter (wraps at 2^16).
module regfile_wr_demux #(
    parameter int XLEN   = rv_pkg::XLEN,
    parameter int NREGS  = rv_pkg::NREGS,
    parameter int AW     = rv_pkg::AW,
    parameter bit BYPASS = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   a1,
    input  logic [AW-1:0]   a2,
    input  logic [AW-1:0]   a3,
    input  logic            we3,
    input  logic [XLEN-1:0] wd3,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    output logic [15:0]     wr_cnt
);
    import rv_pkg::*;

    logic [NREGS-1:0] we_vec;
    logic [XLEN-1:0]  regs [NREGS];

    wr_decoder #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_wr_decoder (
        .a3     (a3),
        .we3    (we3),
        .we_vec (we_vec)
    );

    // Reset takes priority over any write presented in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            wr_cnt <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (we_vec[i]) begin
                    regs[i] <= wd3;
                end
            end
            // we_vec already excludes x0, so a dropped x0 write does not count.
            if (|we_vec) begin
                wr_cnt <= wr_cnt + 16'd1;
            end
        end
    end

    // Forwarding uses the decoded enable so it inherits the x0 exclusion;
    // rst_n gates it because a write during reset never commits.
    function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] addr);
        logic [XLEN-1:0] val;
        val = regs[addr];
        if (BYPASS && rst_n && we_vec[addr]) begin
            val = wd3;
        end
        if (addr == AW'(REG_ZERO)) begin
            val = '0;
        end
        return val;
    endfunction

    always_comb begin
        rd1 = read_port(a1);
        rd2 = read_port(a2);
    end

endmodule
